key_event_encoder: RTL and testbench
====================================

// Module: key_event_encoder
// PURPOSE
//  Sits directly downstream of the keyboard matrix scanner. Consumes its 103-bit
//  key_down map and debounces it with a two-snapshot agreement rule. Emits one
//  8-bit make/break event per debounced key change into an internal FIFO. The
//  host-interface layer drains the FIFO over a valid/ready handshake.
// PARAMETERS
//  SAMPLE_PERIOD  50000  clocks between snapshots (1 ms at 50 MHz); must be >= 128
//  FIFO_DEPTH     16     event FIFO entries; power of two
//  NUM_KEYS       103    key indices 1..NUM_KEYS; must be <= 127
// PORTS
//  clock       in   1         system clock, the single clock domain
//  reset       in   1         asynchronous, active-high reset
//  enabled     in   1         high = snapshots allowed; low = sample counter held at 0
//  key_down    in   103       [103:1] raw key map from scanner, same clock domain
//  ev_data     out  8         [7]=1 make / 0 break; [6:0]=key index 1..103
//  ev_valid    out  1         FIFO head is valid
//  ev_ready    in   1         consumer accepts the head on this clock edge
//  fifo_level  out  5         entries held, 0..FIFO_DEPTH
//  any_key     out  1         OR of the debounced stable map
// BEHAVIOUR
//  Reset (async): all state cleared -> FSM=IDLE, snapshots/stable map=0,
//   FIFO empty, ev_valid=0, ev_data=0, fifo_level=0, any_key=0.
//   A reset mid-sweep discards in-flight work. Keys held through reset produce
//   make events on the second snapshot after reset; no break events are sent.
//  Tick: counter counts 0..SAMPLE_PERIOD-1 while enabled=1 and pulses tick on wrap.
//   A tick arriving while FSM != IDLE is dropped, not queued.
//   Deasserting enabled does not abort a sweep that is already running.
//  FSM states:
//   IDLE    -> CAPTURE on tick.
//   CAPTURE -> one cycle: snap_prev<=snap_cur; snap_cur<=key_down; idx<=1; -> SCAN.
//   SCAN    -> handles one key per cycle at idx. A key changes when
//              snap_cur[idx]==snap_prev[idx] AND snap_cur[idx]!=stable[idx].
//              On change with FIFO not full: push {snap_cur[idx],idx[6:0]},
//              set stable[idx]<=snap_cur[idx], advance idx.
//              On change with FIFO full: stall with idx held; no event is lost.
//              No change: advance idx.
//              When idx==NUM_KEYS is processed -> IDLE.
//  Latency: tick at cycle T -> CAPTURE at T+1 -> key i is scanned at T+1+i plus
//   accumulated stalls -> its event shows on ev_valid/ev_data one cycle after push.
//   Minimum sweep is 105 cycles.
//  FIFO: first-word-fall-through.
//   Pop when ev_valid&&ev_ready. A pop while empty is impossible; ev_valid=0.
//   Push is permitted only when level<FIFO_DEPTH. Full+pop in the same cycle
//   still blocks the push, which retries next cycle.
//   Simultaneous push and pop when not full: level unchanged, order preserved.
//   Pointers wrap modulo FIFO_DEPTH; level is DEPTH+1-valued, 5 bits.
//  Ordering: events within a sweep go in ascending key index. Sweep k's events
//   all precede sweep k+1's.
//  any_key is registered from the stable map and updates the cycle after any
//   stable bit changes.
// STRUCTURE
//  Shared defines file keyboard_defs.vh holds:
//   NUM_KEYS, `SAMPLE_PERIOD, EV_MAKE_BIT=7, EV_CODE_MSB=6, FSM state encodings.
//   The scanner and host-interface layer use the same event format.
//  One sub-module: key_event_fifo (8-bit x FIFO_DEPTH, FWFT, level output).
//  Tick counter, FSM, snapshots and stable map stay in the top level.
// TESTING
//  1 Key 5 pressed for 3 sample periods, then released for 3 -> exactly two
//    events: 0x85 then 0x05; fifo_level peaks at 1 with ev_ready=1.
//  2 Bounce: key 40 toggles every 0.3*SAMPLE_PERIOD for 2 periods, then steady 1
//    -> no event until two consecutive snapshots agree, then a single 0xA8.
//  3 ev_ready=0; 20 keys pressed at once -> 16 events queued, fifo_level=16,
//    FSM stalls at the 17th key; then ev_ready=1 -> all 20 makes arrive in
//    ascending index order, none duplicated or lost.
//  4 Keys 1 and 103 pressed together -> 0x81 then 0xE7. Verifies idx bounds and
//    the [103:1] mapping; key 103 lands ~103 cycles after key 1.
//  5 Assert reset mid-sweep with 3 queued events -> ev_valid=0 and level=0
//    immediately. A held key 10 yields 0x8A after two post-reset snapshots.
//  6 enabled=0 for 5 periods while a key is pressed -> no events and any_key=0;
//    re-enable -> make appears after the second snapshot.

Source files
------------

// File: rtl/key_event_encoder_pkg.sv
// Shared definitions for the key event encoder: event format, FSM states and
// the event packing helper used by the scanner-side logic.
package key_event_encoder_pkg;

    localparam int EV_W        = 8;
    localparam int EV_MAKE_BIT = 7;
    localparam int EV_CODE_MSB = 6;
    localparam int KEY_IDX_W   = EV_CODE_MSB + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_SCAN    = 2'd2
    } scan_state_e;

    typedef logic [EV_W-1:0] key_event_t;

    // Bit 7 flags make (1) or break (0); bits 6:0 carry the key index.
    function automatic key_event_t make_event(input logic is_make,
                                              input logic [KEY_IDX_W-1:0] code);
        return {is_make, code};
    endfunction

endpackage

// File: rtl/key_event_encoder_fifo.sv
// First-word-fall-through event FIFO with an occupancy output that can
// represent both empty and full (DEPTH+1 values).
module key_event_fifo
    import key_event_encoder_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  key_event_t         push_data,
    input  logic               pop_ready,
    output logic               full,
    output logic               ev_valid,
    output key_event_t         ev_data,
    output logic [LEVEL_W-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    key_event_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (level == LEVEL_W'(DEPTH));
    assign ev_valid = (level != '0);
    assign ev_data  = ev_valid ? mem[rd_ptr] : '0;
    assign push_ok  = push && !full;
    assign pop_ok   = ev_valid && pop_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LEVEL_W'(1);
                2'b01:   level <= level - LEVEL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // NOTE: storage is deliberately left out of reset; level gates every read,
    // so stale contents are never visible and the array maps onto plain RAM.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/key_event_encoder.sv
// Debounces the scanner's key map with a two-snapshot agreement rule and queues
// one make/break event per debounced change for the host interface.
module key_event_encoder
    import key_event_encoder_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 50000,
    parameter int FIFO_DEPTH    = 16,
    parameter int NUM_KEYS      = 103
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enabled,
    input  logic [NUM_KEYS:1]           key_down,
    output logic [EV_W-1:0]             ev_data,
    output logic                        ev_valid,
    input  logic                        ev_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        any_key
);

    localparam int                   CNT_W    = $clog2(SAMPLE_PERIOD);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [KEY_IDX_W-1:0] LAST_IDX = KEY_IDX_W'(NUM_KEYS);

    logic [CNT_W-1:0]     sample_cnt;
    logic                 tick;
    scan_state_e          state;
    scan_state_e          state_next;
    logic [NUM_KEYS:1]    snap_prev;
    logic [NUM_KEYS:1]    snap_cur;
    logic [NUM_KEYS:1]    stable;
    logic [KEY_IDX_W-1:0] idx;
    logic                 key_changed;
    logic                 capture_en;
    logic                 push;
    logic                 advance;
    logic                 fifo_full;
    key_event_t           push_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sample_cnt <= '0;
        end else if (!enabled || sample_cnt == CNT_LAST) begin
            sample_cnt <= '0;
        end else begin
            sample_cnt <= sample_cnt + CNT_W'(1);
        end
    end

    assign tick = enabled && (sample_cnt == CNT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // A tick seen outside IDLE is simply ignored, never remembered.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (tick) state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = ST_SCAN;
            ST_SCAN:    if (advance && idx == LAST_IDX) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    assign key_changed = (snap_cur[idx] == snap_prev[idx]) &&
                         (snap_cur[idx] != stable[idx]);

    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        capture_en = 1'b0;
        push       = 1'b0;
        advance    = 1'b0;
        case (state)
            ST_CAPTURE: capture_en = 1'b1;
            ST_SCAN: begin
                push    = key_changed && !fifo_full;
                advance = !key_changed || !fifo_full;
            end
            default: ;
        endcase
    end

    // idx never leaves 1..NUM_KEYS, so the [NUM_KEYS:1] maps are always in range.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            snap_prev <= '0;
            snap_cur  <= '0;
            stable    <= '0;
            idx       <= KEY_IDX_W'(1);
            any_key   <= 1'b0;
        end else begin
            if (capture_en) begin
                snap_prev <= snap_cur;
                snap_cur  <= key_down;
                idx       <= KEY_IDX_W'(1);
            end else if (advance && idx != LAST_IDX) begin
                idx <= idx + KEY_IDX_W'(1);
            end
            if (push) stable[idx] <= snap_cur[idx];
            any_key <= |stable;
        end
    end

    assign push_data = make_event(snap_cur[idx], idx);

    key_event_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .LEVEL_W ($clog2(FIFO_DEPTH) + 1)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop_ready (ev_ready),
        .full      (fifo_full),
        .ev_valid  (ev_valid),
        .ev_data   (ev_data),
        .level     (fifo_level)
    );

endmodule

// File: tb/tb_key_event_encoder.sv
// Directed bench for key_event_encoder with a short sample period; a posedge
// monitor logs every accepted event and its cycle number.
module tb_key_event_encoder;

    localparam int SP = 200;
    localparam int NK = 103;

    logic          clock = 1'b0;
    logic          reset;
    logic          enabled;
    logic [NK:1]   key_down;
    logic [7:0]    ev_data;
    logic          ev_valid;
    logic          ev_ready;
    logic [4:0]    fifo_level;
    logic          any_key;

    int            compared   = 0;
    int            mismatched = 0;
    int            cyc        = 0;
    int            peak_level = 0;
    int            t0         = 0;
    logic [7:0]    cap [$];
    int            cap_t [$];

    always #5 clock = ~clock;

    key_event_encoder #(
        .SAMPLE_PERIOD (SP),
        .FIFO_DEPTH    (16),
        .NUM_KEYS      (NK)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enabled    (enabled),
        .key_down   (key_down),
        .ev_data    (ev_data),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .fifo_level (fifo_level),
        .any_key    (any_key)
    );

    // Handshake monitor: values read here are the pre-edge values the DUT sees.
    always @(posedge clock) begin
        cyc = cyc + 1;
        if (ev_valid === 1'b1 && ev_ready === 1'b1) begin
            cap.push_back(ev_data);
            cap_t.push_back(cyc);
        end
        if (int'(fifo_level) > peak_level) peak_level = int'(fifo_level);
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Restart the sample counter so snapshots land at SP+1, 2SP+1, ... after t0.
    task automatic resync();
        enabled = 1'b0;
        run(1);
        enabled = 1'b1;
        t0 = cyc;
    endtask

    initial begin
        reset    = 1'b1;
        enabled  = 1'b0;
        ev_ready = 1'b1;
        key_down = '0;
        run(3);
        check("rst_ev_valid", ev_valid, 0);
        check("rst_ev_data", ev_data, 0);
        check("rst_level", fifo_level, 0);
        check("rst_any_key", any_key, 0);
        reset   = 1'b0;
        enabled = 1'b1;
        run(2);

        // Test 1: key 5 press and release
        peak_level = 0;
        cap.delete(); cap_t.delete();
        resync();
        key_down[5] = 1'b1;
        run(3 * SP);
        check("t1_make_count", cap.size(), 1);
        check("t1_any_key_on", any_key, 1);
        key_down[5] = 1'b0;
        run(3 * SP);
        check("t1_count", cap.size(), 2);
        check("t1_make", cap[0], 8'h85);
        check("t1_break", cap[1], 8'h05);
        check("t1_make_time", cap_t[0] - t0, 2 * SP + 7);
        check("t1_peak", peak_level, 1);
        check("t1_any_key_off", any_key, 0);

        // Test 3: 20 simultaneous keys against a blocked consumer
        cap.delete(); cap_t.delete();
        peak_level = 0;
        ev_ready = 1'b0;
        resync();
        for (int k = 50; k < 70; k++) key_down[k] = 1'b1;
        run(2 * SP + 150);
        check("t3_level_full", fifo_level, 16);
        check("t3_valid", ev_valid, 1);
        check("t3_head", ev_data, 8'hB2);
        run(SP);
        check("t3_still_full", fifo_level, 16);
        ev_ready = 1'b1;
        run(150);
        check("t3_count", cap.size(), 20);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("t3_ev%0d", i), cap[i], 32'h80 | (50 + i));
        end
        check("t3_drained", fifo_level, 0);
        check("t3_peak", peak_level, 16);
        cap.delete(); cap_t.delete();
        resync();
        for (int k = 50; k < 70; k++) key_down[k] = 1'b0;
        run(2 * SP + 150);
        check("t3_breaks", cap.size(), 20);

        // Test 2: bouncing key 40, snapshots sample 1, 0, 1, 1
        cap.delete(); cap_t.delete();
        resync();
        run(SP - 10);
        for (int i = 0; i < 400; i++) begin
            key_down[40] = ((i / 60) % 2 == 0);
            run(1);
        end
        key_down[40] = 1'b1;
        check("t2_quiet_bounce", cap.size(), 0);
        run(200);
        check("t2_quiet_settle", cap.size(), 0);
        run(100);
        check("t2_count", cap.size(), 1);
        check("t2_make", cap[0], 8'hA8);
        check("t2_time", cap_t[0] - t0, 4 * SP + 42);

        // Test 4: index bounds, keys 1 and 103
        cap.delete(); cap_t.delete();
        resync();
        key_down[1]   = 1'b1;
        key_down[103] = 1'b1;
        run(2 * SP + 150);
        check("t4_count", cap.size(), 2);
        check("t4_key1", cap[0], 8'h81);
        check("t4_key103", cap[1], 8'hE7);
        check("t4_key1_time", cap_t[0] - t0, 2 * SP + 3);
        check("t4_spacing", cap_t[1] - cap_t[0], 102);

        // Test 5: reset mid-sweep with three queued events
        cap.delete(); cap_t.delete();
        ev_ready = 1'b0;
        resync();
        key_down[10] = 1'b1;
        key_down[11] = 1'b1;
        key_down[12] = 1'b1;
        run(2 * SP + 30);
        check("t5_level_pre", fifo_level, 3);
        check("t5_head_pre", ev_data, 8'h8A);
        check("t5_any_key_pre", any_key, 1);
        reset = 1'b1;
        #1;
        check("t5_rst_valid", ev_valid, 0);
        check("t5_rst_level", fifo_level, 0);
        check("t5_rst_data", ev_data, 0);
        check("t5_rst_any_key", any_key, 0);
        key_down     = '0;
        key_down[10] = 1'b1;
        run(2);
        reset    = 1'b0;
        ev_ready = 1'b1;
        t0       = cyc;
        run(SP + 150);
        check("t5_one_snapshot", cap.size(), 0);
        run(SP);
        check("t5_count", cap.size(), 1);
        check("t5_make", cap[0], 8'h8A);
        check("t5_time", cap_t[0] - t0, 2 * SP + 12);

        // Test 6: sampling held off while a key is down
        key_down[10] = 1'b0;
        run(2 * SP + 200);
        cap.delete(); cap_t.delete();
        enabled      = 1'b0;
        key_down[20] = 1'b1;
        run(5 * SP);
        check("t6_disabled_count", cap.size(), 0);
        check("t6_disabled_any_key", any_key, 0);
        check("t6_disabled_level", fifo_level, 0);
        enabled = 1'b1;
        t0      = cyc;
        run(SP + 150);
        check("t6_one_snapshot", cap.size(), 0);
        run(SP);
        check("t6_count", cap.size(), 1);
        check("t6_make", cap[0], 8'h94);
        check("t6_time", cap_t[0] - t0, 2 * SP + 22);
        check("t6_any_key", any_key, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
